vga_timing: RTL and testbench

- Raster timing generator for the VGA output path. Sits directly upstream of the pixel bit generator.
- Divides the system clock into a pixel-rate enable and runs horizontal/vertical pixel counters.
- Produces hsync, vsync, the "bright" signal vga_blank_n, and the current pixel coordinates, which the bit generator consumes to colour pixels.
- Defaults give 640x480 @ 60 Hz from a 50 MHz clock.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_clk_div.sv | 36 +++
 rtl/vga_timing.sv | 126 ++++++++++++
 tb/tb_vga_timing.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, coordinate
// type and the timing-to-bit-generator bundle.
package vga_pkg;

  localparam int VGA_CLK_DIV   = 2;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_COORD_W   = 10;
  localparam int VGA_COORD_MAX = 1 << VGA_COORD_W;

  typedef logic [VGA_COORD_W-1:0] vga_coord_t;

  // Everything the bit generator needs to colour the current pixel.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    vga_coord_t hcount;
    vga_coord_t vcount;
  } vga_timing_t;

  // True when lo <= c < hi. Bounds are ints so hi may reach VGA_COORD_MAX.
  function automatic logic in_window(input vga_coord_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_clk_div.sv
// Pixel-rate divider: produces the one-clk pix_en strobe and the DAC pixel
// clock. vga_clk falls on the same edge that advances the raster counters.
module vga_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic vga_clk
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt;

  // Free-running 0..CLK_DIV-1 counter.
  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignment for every registered value so all flops
      // sample the pre-edge state regardless of statement order.
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pix_en  = (div_cnt == DIV_LAST);
  assign vga_clk = (div_cnt >= DIV_HALF);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel divider, horizontal/vertical counters and
// zero-latency sync/blank decodes for the VGA bit generator.
// Optional feature macro: VGA_TIMING_FRAME_STROBE_EN adds frame_start and
// frame_cnt outputs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic        vga_clk,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_blank_n,
  output logic        vga_sync_n
`ifdef VGA_TIMING_FRAME_STROBE_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_LO = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_HI = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_SYNC_LO = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_HI = V_VISIBLE + V_FRONT + V_SYNC;

  // Refuse to build a raster the 10-bit counters cannot address.
  if (H_TOTAL > VGA_COORD_MAX) begin : g_h_total_too_big
    $error("vga_timing: H_TOTAL exceeds 10-bit counter range");
  end
  if (V_TOTAL > VGA_COORD_MAX) begin : g_v_total_too_big
    $error("vga_timing: V_TOTAL exceeds 10-bit counter range");
  end
  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_clk_div_bad
    $error("vga_timing: CLK_DIV must be even and at least 2");
  end

  localparam vga_coord_t H_LAST = vga_coord_t'(H_TOTAL - 1);
  localparam vga_coord_t V_LAST = vga_coord_t'(V_TOTAL - 1);

  vga_coord_t  h_q;
  vga_coord_t  v_q;
  vga_timing_t tim;
  logic        frame_wrap;

  vga_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .vga_clk (vga_clk)
  );

  // Raster counters: advance one pixel per pix_en, line step on h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_en) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  // Sync and visible-area decodes straight from the counter registers.
  always_comb begin
    // NOTE: the whole struct gets a default first so no field can hold its
    // old value and infer a latch.
    tim         = '0;
    tim.hcount  = h_q;
    tim.vcount  = v_q;
    tim.hsync   = !in_window(h_q, H_SYNC_LO, H_SYNC_HI);
    tim.vsync   = !in_window(v_q, V_SYNC_LO, V_SYNC_HI);
    tim.blank_n = in_window(h_q, 0, H_VISIBLE) && in_window(v_q, 0, V_VISIBLE);
  end

  assign frame_wrap  = pix_en && (h_q == H_LAST) && (v_q == V_LAST);

  assign hcount      = tim.hcount;
  assign vcount      = tim.vcount;
  assign hsync       = tim.hsync;
  assign vsync       = tim.vsync;
  assign vga_blank_n = tim.blank_n;
  assign vga_sync_n  = 1'b0;

`ifdef VGA_TIMING_FRAME_STROBE_EN
  // Frame strobe and frame counter, both updated on the (0,0) wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  // Wrap detect is only consumed by the frame strobe; keep it visibly used.
  logic frame_wrap_unused;
  assign frame_wrap_unused = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing. A default 640x480 instance covers reset,
// divider and line timing; a shrunken-raster instance covers whole frames,
// mid-frame reset, random resets and the optional frame strobe.
module tb_vga_timing;

  // Small raster: 32 x 17 pixels, 4 clks per pixel.
  localparam int S_CD = 4;
  localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_CD * S_HT * S_VT;

  typedef struct packed {
    logic       pix_en;
    logic       vga_clk;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic [9:0] h;
    logic [9:0] v;
  } obs_t;

  localparam obs_t RESET_OBS = '{pix_en: 1'b0, vga_clk: 1'b0, hsync: 1'b1,
                                 vsync: 1'b1, blank_n: 1'b1, h: 10'd0, v: 10'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  logic       pe_d, vc_d, hs_d, vs_d, bl_d, sn_d;
  logic [9:0] hc_d, vcn_d;
  logic       pe_s, vc_s, hs_s, vs_s, bl_s, sn_s;
  logic [9:0] hc_s, vcn_s;
`ifdef VGA_TIMING_FRAME_STROBE_EN
  logic        fs_d, fs_s;
  logic [15:0] fc_d, fc_s;
`endif

  obs_t obs_d, obs_s;
  assign obs_d = {pe_d, vc_d, hs_d, vs_d, bl_d, hc_d, vcn_d};
  assign obs_s = {pe_s, vc_s, hs_s, vs_s, bl_s, hc_s, vcn_s};

  int checks = 0;
  int errors = 0;

  // Model state: clock edges seen since the last edge with reset asserted.
  longint n_d = 0;
  longint n_s = 0;
  always @(posedge clk) begin
    n_d <= rst_d ? 64'd0 : n_d + 1;
    n_s <= rst_s ? 64'd0 : n_s + 1;
  end

  vga_timing dut_d (
    .clk         (clk),
    .rst         (rst_d),
    .pix_en      (pe_d),
    .vga_clk     (vc_d),
    .hcount      (hc_d),
    .vcount      (vcn_d),
    .hsync       (hs_d),
    .vsync       (vs_d),
    .vga_blank_n (bl_d),
    .vga_sync_n  (sn_d)
`ifdef VGA_TIMING_FRAME_STROBE_EN
    ,
    .frame_start (fs_d),
    .frame_cnt   (fc_d)
`endif
  );

  vga_timing #(
    .CLK_DIV (S_CD),
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) dut_s (
    .clk         (clk),
    .rst         (rst_s),
    .pix_en      (pe_s),
    .vga_clk     (vc_s),
    .hcount      (hc_s),
    .vcount      (vcn_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .vga_blank_n (bl_s),
    .vga_sync_n  (sn_s)
`ifdef VGA_TIMING_FRAME_STROBE_EN
    ,
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
`endif
  );

  // Reference: after n post-reset edges, floor(n/cd) pixels have elapsed;
  // the raster position is that pixel index folded into lines and frames.
  function automatic obs_t model(input longint n, input int cd,
                                 input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb);
    obs_t   m;
    int     ht  = hv + hf + hs + hb;
    int     vt  = vv + vf + vs + vb;
    longint pix = n / cd;
    int     ph  = int'(n % cd);
    int     h   = int'(pix % ht);
    int     v   = int'((pix / ht) % vt);
    m.pix_en  = (ph == cd - 1);
    m.vga_clk = (ph >= cd / 2);
    m.hsync   = !(h >= hv + hf && h < hv + hf + hs);
    m.vsync   = !(v >= vv + vf && v < vv + vf + vs);
    m.blank_n = (h < hv) && (v < vv);
    m.h       = 10'(h);
    m.v       = 10'(v);
    return m;
  endfunction

  function automatic obs_t model_d(input longint n);
    return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_s(input longint n);
    return model(n, S_CD, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
  endfunction

  // Frame strobe reference: high for the clk after every completed frame.
  function automatic logic [16:0] model_frame(input longint n);
    longint pix   = n / S_CD;
    longint fpix  = longint'(S_HT) * S_VT;
    logic   start = (n % S_CD == 0) && (pix > 0) && (pix % fpix == 0);
    return {start, 16'((pix / fpix) % 65536)};
  endfunction

  task automatic test_reset();
    obs_t e;
    rst_d = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_d !== RESET_OBS) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_d, RESET_OBS);
    end
    checks++;
    if (sn_d !== 1'b0) begin
      errors++;
      $display("FAIL sync_n_tied got=%b exp=0", sn_d);
    end
    rst_d = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = model_d(n_d);
      checks++;
      if (obs_d !== e) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%h exp=%h", k, obs_d, e);
      end
      if (k == 1) begin
        checks++;
        if (pe_d !== 1'b1 || hc_d !== 10'd0) begin
          errors++;
          $display("FAIL first_pix_en pix_en=%b hcount=%0d exp pix_en=1 hcount=0", pe_d, hc_d);
        end
      end
      if (k == 2) begin
        checks++;
        if (hc_d !== 10'd1) begin
          errors++;
          $display("FAIL hcount_after_first got=%0d exp=1", hc_d);
        end
      end
    end
  endtask

  task automatic test_divider();
    obs_t e;
    int   clk_hi = 0;
    int   pe_hi  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      e = model_d(n_d);
      clk_hi += int'(vc_d);
      pe_hi  += int'(pe_d);
      checks++;
      if (obs_d !== e) begin
        errors++;
        $display("FAIL divider k=%0d got=%h exp=%h", k, obs_d, e);
      end
    end
    checks++;
    if (clk_hi != 5 || pe_hi != 5) begin
      errors++;
      $display("FAIL divider_duty vga_clk_high=%0d pix_en_high=%0d exp 5 and 5", clk_hi, pe_hi);
    end
  endtask

  task automatic test_line();
    obs_t       e;
    int         hs_low   = 0;
    int         blank_at = -1;
    int         v_at_wrap = -1;
    logic       prev_bl  = 1'b1;
    logic [9:0] prev_h   = '0;
    rst_d = 1'b1;
    @(negedge clk);
    rst_d = 1'b0;
    for (int k = 0; k < 1610; k++) begin
      @(negedge clk);
      e = model_d(n_d);
      checks++;
      if (obs_d !== e) begin
        errors++;
        $display("FAIL line k=%0d got=%h exp=%h", k, obs_d, e);
      end
      if (hs_d === 1'b0) hs_low++;
      if (prev_bl === 1'b1 && bl_d === 1'b0 && blank_at < 0) blank_at = int'(hc_d);
      if (prev_h == 10'd799 && hc_d == 10'd0) v_at_wrap = int'(vcn_d);
      prev_bl = bl_d;
      prev_h  = hc_d;
    end
    checks++;
    if (hs_low != 192) begin
      errors++;
      $display("FAIL hsync_width got=%0d clks exp=192", hs_low);
    end
    checks++;
    if (blank_at != 640) begin
      errors++;
      $display("FAIL blank_fall got=%0d exp=640", blank_at);
    end
    checks++;
    if (v_at_wrap != 1) begin
      errors++;
      $display("FAIL line_wrap_vcount got=%0d exp=1", v_at_wrap);
    end
  endtask

  task automatic test_frame();
    obs_t e;
    int   vs_low = 0;
    int   wraps  = 0;
    int   wrap_t[2];
    logic prev_origin = 1'b1;
    logic origin;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    for (int k = 1; k <= 2 * S_FRAME + 10; k++) begin
      @(negedge clk);
      e = model_s(n_s);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL frame k=%0d got=%h exp=%h", k, obs_s, e);
      end
      if (vs_s === 1'b0) vs_low++;
      origin = (hc_s == 10'd0) && (vcn_s == 10'd0);
      if (origin && !prev_origin) begin
        if (wraps < 2) wrap_t[wraps] = k;
        wraps++;
      end
      prev_origin = origin;
    end
    checks++;
    if (vs_low != 2 * S_VS * S_HT * S_CD) begin
      errors++;
      $display("FAIL vsync_width got=%0d clks exp=%0d", vs_low, 2 * S_VS * S_HT * S_CD);
    end
    checks++;
    if (wraps != 2 || wrap_t[1] - wrap_t[0] != S_FRAME) begin
      errors++;
      $display("FAIL frame_period wraps=%0d period=%0d exp wraps=2 period=%0d",
               wraps, wrap_t[1] - wrap_t[0], S_FRAME);
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    int   waited = 0;
    // Wait for the back-porch pixel of the second vsync line.
    while (!(hc_s == 10'(S_HT - 4) && vcn_s == 10'(S_VV + S_VF + 1)) && waited < 2 * S_FRAME) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 2 * S_FRAME || vs_s !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_reach h=%0d v=%0d vsync=%b exp h=%0d v=%0d vsync=0",
               hc_s, vcn_s, vs_s, S_HT - 4, S_VV + S_VF + 1);
    end
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    checks++;
    if (obs_s !== RESET_OBS) begin
      errors++;
      $display("FAIL mid_reset_state got=%h exp=%h", obs_s, RESET_OBS);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = model_s(n_s);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL mid_reset_after k=%0d got=%h exp=%h", k, obs_s, e);
      end
    end
  endtask

  task automatic test_random_resets();
    obs_t e;
    int   len;
    for (int it = 0; it < 25; it++) begin
      len = int'($urandom_range(50, 400));
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        e = model_s(n_s);
        checks++;
        if (obs_s !== e) begin
          errors++;
          $display("FAIL random it=%0d k=%0d rst=%b got=%h exp=%h", it, k, rst_s, obs_s, e);
        end
      end
      rst_s = ($urandom_range(0, 2) == 0);
      if (rst_s) begin
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        rst_s = 1'b0;
      end
    end
  endtask

`ifdef VGA_TIMING_FRAME_STROBE_EN
  task automatic test_frame_strobe();
    logic [16:0] e;
    int          pulses = 0;
    int          pulse_t[3];
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    for (int k = 1; k <= 3 * S_FRAME + 20; k++) begin
      @(negedge clk);
      e = model_frame(n_s);
      checks++;
      if ({fs_s, fc_s} !== e) begin
        errors++;
        $display("FAIL frame_strobe k=%0d got=%b/%0d exp=%b/%0d", k, fs_s, fc_s, e[16], e[15:0]);
      end
      if (fs_s === 1'b1) begin
        if (pulses < 3) pulse_t[pulses] = k;
        pulses++;
        checks++;
        if (fc_s !== 16'(pulses)) begin
          errors++;
          $display("FAIL frame_cnt got=%0d exp=%0d", fc_s, pulses);
        end
      end
    end
    checks++;
    if (pulses != 3 || pulse_t[1] - pulse_t[0] != S_FRAME || pulse_t[2] - pulse_t[1] != S_FRAME) begin
      errors++;
      $display("FAIL frame_pulses count=%0d gaps=%0d,%0d exp count=3 gaps=%0d",
               pulses, pulse_t[1] - pulse_t[0], pulse_t[2] - pulse_t[1], S_FRAME);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divider();
    test_line();
    test_frame();
    test_mid_reset();
    test_random_resets();
`ifdef VGA_TIMING_FRAME_STROBE_EN
    test_frame_strobe();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
